// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: blocking N-way set-associative read-only cache with round-robin refill,
// single-cycle flush and saturating hit/miss counters.
module assoc_cache_ctrl #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32,
  parameter int WPL    = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WORD_W-1:0]     resp_data,
  output logic                  resp_hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [WPL*WORD_W-1:0] mem_rdata,
  input  logic                  flush,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);
  localparam int LINE_W = WPL * WORD_W;
  localparam int OFF_W  = $clog2(WPL);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = WAYS > 1 ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [WAYS-1:0]    valid  [SETS];
  logic [WAY_W-1:0]   victim [SETS];
  logic [TAG_W-1:0]   tags   [SETS][WAYS];
  logic [LINE_W-1:0]  lines  [SETS][WAYS];
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   idx;
  logic [OFF_W-1:0]   off;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   vic;
  logic [WAY_W-1:0]   vic_next;

  assign {tag, idx, off} = addr;
  assign req_ready = (state == IDLE) && !flush;
  assign stall     = ~req_ready;
  assign vic       = victim[idx];
  assign vic_next  = (int'(vic) == WAYS - 1) ? '0 : vic + 1'b1;

  // Descending scan so the lowest matching way wins on an illegal multi-hit.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  function automatic logic [WORD_W-1:0] pick(input logic [LINE_W-1:0] l, input logic [OFF_W-1:0] o);
    return l[LINE_W-1-WORD_W*int'(o) -: WORD_W];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_hit   <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        victim[s] <= '0;
      end
    end else begin
      unique case (state)
        IDLE:
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              valid[s]  <= '0;
              victim[s] <= '0;
            end
          end else if (req_valid) begin
            addr  <= req_addr;
            state <= LOOKUP;
          end
        LOOKUP:
          if (hit) begin
            resp_data  <= pick(lines[idx][hit_way], off);
            resp_hit   <= 1'b1;
            resp_valid <= 1'b1;
            hit_cnt    <= hit_cnt + CNT_W'(hit_cnt != '1);
            state      <= RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= {tag, idx, OFF_W'(0)};
            miss_cnt <= miss_cnt + CNT_W'(miss_cnt != '1);
            state    <= REFILL;
          end
        REFILL:
          if (mem_ack) begin
            valid[idx][vic] <= 1'b1;
            victim[idx]     <= vic_next;
            resp_data       <= pick(mem_rdata, off);
            resp_hit        <= 1'b0;
            resp_valid      <= 1'b1;
            mem_req         <= 1'b0;
            state           <= RESP;
          end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk)
    if (state == REFILL && mem_ack) begin
      tags[idx][vic]  <= tag;
      lines[idx][vic] <= mem_rdata;
    end
endmodule
